// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock parametrised FIFO.
package sync_fifo_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 16;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned AW_DEF = ptr_width(DEPTH_DEF);

  // Thresholds and fill level need one extra bit to represent DEPTH itself.
  typedef logic [AW_DEF:0] level_def_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port, no reset.
module sync_fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with programmable almost-full/empty thresholds and live fill level.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output instead of a registered read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             rd_ack,
  output logic             rd_err,
  output logic             empty,
  output logic             almost_empty,
  input  logic [AW:0]      af_thresh,
  input  logic [AW:0]      ae_thresh,
  output logic [AW:0]      count
);

  localparam int unsigned CntW = AW + 1;
  localparam logic [AW:0] DepthC = CntW'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_data;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DepthC);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);
  assign count        = count_q;

  // A read must see a stored word; a write at full is allowed only when a read frees a slot.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      wr_ack_q <= wr_acc;
      wr_err_q <= wr_en && !wr_acc;
      rd_ack_q <= rd_acc;
      rd_err_q <= rd_en && !rd_acc;
    end
  end

  assign wr_ack = wr_ack_q;
  assign wr_err = wr_err_q;
  assign rd_ack = rd_ack_q;
  assign rd_err = rd_err_q;

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign dout = empty ? '0 : rd_data;
`else
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= rd_data;
    end
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=16, af=14, ae=2).
module tb_sync_fifo_param;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic             clk = 1'b0;
  logic             clear_n = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             wr_ack, wr_err, full, almost_full;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             rd_ack, rd_err, empty, almost_empty;
  logic [AW:0]      af_thresh = 5'd14;
  logic [AW:0]      ae_thresh = 5'd2;
  logic [AW:0]      count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .wr_en        (wr_en),
    .din          (din),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .dout         (dout),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err),
    .empty        (empty),
    .almost_empty (almost_empty),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .count        (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses packed as {wr_ack, wr_err, rd_ack, rd_err}; flags as {empty, ae, af, full}.
  task automatic test_reset();
    #3 clear_n = 1'b0;
    #1;
    n_vec++;
    if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000) begin
      n_err++; $display("FAIL reset_pulses got %b want 0000", {wr_ack, wr_err, rd_ack, rd_err});
    end
    n_vec++;
    if ({empty, almost_empty, almost_full, full} !== 4'b1100 || count !== 5'd0 || dout !== 8'h00)
    begin
      n_err++;
      $display("FAIL reset_state got flags=%b count=%0d dout=%h want flags=1100 count=0 dout=00",
               {empty, almost_empty, almost_full, full}, count, dout);
    end
    af_thresh = 5'd0;
    #1;
    n_vec++;
    if (almost_full !== 1'b1) begin
      n_err++; $display("FAIL reset_af_zero got %b want 1", almost_full);
    end
    af_thresh = 5'd14;
    step();
    clear_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    logic [3:0] exp_flags;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1;
      din   = 8'(i);
      step();
      exp_flags = {1'b0, (i <= 2), (i >= 14), (i == 16)};
      n_vec++;
      if (wr_ack !== 1'b1 || wr_err !== 1'b0 || count !== 5'(i)) begin
        n_err++;
        $display("FAIL fill_ack[%0d] got ack=%b err=%b count=%0d want ack=1 err=0 count=%0d",
                 i, wr_ack, wr_err, count, i);
      end
      n_vec++;
      if ({empty, almost_empty, almost_full, full} !== exp_flags) begin
        n_err++;
        $display("FAIL fill_flags[%0d] got %b want %b", i,
                 {empty, almost_empty, almost_full, full}, exp_flags);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_dout;
`ifdef SYNC_FIFO_FWFT_EN
    exp_dout = 8'h01;
`else
    exp_dout = 8'h00;
`endif
    wr_en = 1'b1;
    din   = 8'hEE;
    step();
    n_vec++;
    if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0100 || count !== 5'd16 || full !== 1'b1) begin
      n_err++;
      $display("FAIL overflow got pulses=%b count=%0d full=%b want pulses=0100 count=16 full=1",
               {wr_ack, wr_err, rd_ack, rd_err}, count, full);
    end
    wr_en = 1'b0;
    step();
    n_vec++;
    if (wr_err !== 1'b0 || dout !== exp_dout) begin
      n_err++;
      $display("FAIL overflow_pulse_end got err=%b dout=%h want err=0 dout=%h",
               wr_err, dout, exp_dout);
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_dout;
`ifdef SYNC_FIFO_FWFT_EN
    exp_dout = 8'h02;
`else
    exp_dout = 8'h01;
`endif
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 8'hAA;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_vec++;
    if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b1010 || count !== 5'd16 || dout !== exp_dout) begin
      n_err++;
      $display("FAIL full_rw got pulses=%b count=%0d dout=%h want pulses=1010 count=16 dout=%h",
               {wr_ack, wr_err, rd_ack, rd_err}, count, dout, exp_dout);
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp;
    for (int k = 0; k < 16; k++) begin
      exp = (k == 15) ? 8'hAA : 8'(k + 2);
      rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      #0;
      n_vec++;
      if (dout !== exp) begin
        n_err++; $display("FAIL drain_head[%0d] got %h want %h", k, dout, exp);
      end
`endif
      step();
      n_vec++;
      if (rd_ack !== 1'b1 || rd_err !== 1'b0) begin
        n_err++; $display("FAIL drain_ack[%0d] got ack=%b err=%b want 1 0", k, rd_ack, rd_err);
      end
`ifndef SYNC_FIFO_FWFT_EN
      n_vec++;
      if (dout !== exp) begin
        n_err++; $display("FAIL drain_data[%0d] got %h want %h", k, dout, exp);
      end
`endif
    end
    rd_en = 1'b0;
    n_vec++;
    if (count !== 5'd0 || {empty, almost_empty, almost_full, full} !== 4'b1100) begin
      n_err++;
      $display("FAIL drain_end got count=%0d flags=%b want count=0 flags=1100",
               count, {empty, almost_empty, almost_full, full});
    end
  endtask

  task automatic test_empty_read();
    logic [7:0] held;
`ifdef SYNC_FIFO_FWFT_EN
    held = 8'h00;
`else
    held = 8'hAA;
`endif
    rd_en = 1'b1;
    step();
    n_vec++;
    if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0001 || dout !== held) begin
      n_err++;
      $display("FAIL empty_read got pulses=%b dout=%h want pulses=0001 dout=%h",
               {wr_ack, wr_err, rd_ack, rd_err}, dout, held);
    end
    wr_en = 1'b1;
    din   = 8'h55;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_vec++;
    if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b1001 || count !== 5'd1) begin
      n_err++;
      $display("FAIL empty_rw got pulses=%b count=%0d want pulses=1001 count=1",
               {wr_ack, wr_err, rd_ack, rd_err}, count);
    end
`ifdef SYNC_FIFO_FWFT_EN
    held = 8'h55;
`endif
    n_vec++;
    if (dout !== held) begin
      n_err++; $display("FAIL empty_rw_dout got %h want %h", dout, held);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_vec++;
    if (rd_ack !== 1'b1 || count !== 5'd0) begin
      n_err++; $display("FAIL pop_55 got ack=%b count=%0d want 1 0", rd_ack, count);
    end
`ifndef SYNC_FIFO_FWFT_EN
    n_vec++;
    if (dout !== 8'h55) begin
      n_err++; $display("FAIL pop_55_data got %h want 55", dout);
    end
`endif
  endtask

  // Write i while reading i-1; 40 words move through with pointers starting at 2.
  task automatic test_wrap();
    for (int i = 0; i <= 40; i++) begin
      wr_en = (i < 40);
      din   = 8'(i);
      rd_en = (i > 0);
`ifdef SYNC_FIFO_FWFT_EN
      #0;
      if (i > 0) begin
        n_vec++;
        if (dout !== 8'(i - 1)) begin
          n_err++; $display("FAIL wrap_head[%0d] got %h want %h", i - 1, dout, 8'(i - 1));
        end
      end
`endif
      step();
      n_vec++;
      if (wr_err !== 1'b0 || rd_err !== 1'b0) begin
        n_err++; $display("FAIL wrap_err[%0d] got wr_err=%b rd_err=%b want 0 0", i, wr_err, rd_err);
      end
      if (i > 0) begin
        n_vec++;
        if (rd_ack !== 1'b1) begin
          n_err++; $display("FAIL wrap_ack[%0d] got %b want 1", i - 1, rd_ack);
        end
`ifndef SYNC_FIFO_FWFT_EN
        n_vec++;
        if (dout !== 8'(i - 1)) begin
          n_err++; $display("FAIL wrap_data[%0d] got %h want %h", i - 1, dout, 8'(i - 1));
        end
`endif
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_vec++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL wrap_end got count=%0d empty=%b want 0 1", count, empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1;
      din   = 8'(8'h80 + i);
      step();
    end
    n_vec++;
    if (count !== 5'd9 || wr_ack !== 1'b1) begin
      n_err++; $display("FAIL mid_fill got count=%0d ack=%b want 9 1", count, wr_ack);
    end
    clear_n = 1'b0;
    #1;
    n_vec++;
    if (count !== 5'd0 || {empty, almost_empty, almost_full, full} !== 4'b1100 ||
        {wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000 || dout !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset got count=%0d flags=%b pulses=%b dout=%h want 0 1100 0000 00",
               count, {empty, almost_empty, almost_full, full},
               {wr_ack, wr_err, rd_ack, rd_err}, dout);
    end
    wr_en = 1'b0;
    step();
    clear_n = 1'b1;
    step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_vec++;
    if (rd_err !== 1'b1 || rd_ack !== 1'b0) begin
      n_err++; $display("FAIL post_reset_read got err=%b ack=%b want 1 0", rd_err, rd_ack);
    end
    wr_en = 1'b1;
    din   = 8'h3C;
    step();
    wr_en = 1'b0;
    n_vec++;
`ifdef SYNC_FIFO_FWFT_EN
    if (dout !== 8'h3C || empty !== 1'b0) begin
      n_err++; $display("FAIL fwft_show got dout=%h empty=%b want 3c 0", dout, empty);
    end
`else
    if (dout !== 8'h00 || empty !== 1'b0) begin
      n_err++; $display("FAIL reg_hold got dout=%h empty=%b want 00 0", dout, empty);
    end
`endif
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_vec++;
`ifdef SYNC_FIFO_FWFT_EN
    if (rd_ack !== 1'b1 || dout !== 8'h00 || empty !== 1'b1) begin
      n_err++; $display("FAIL fwft_pop got ack=%b dout=%h empty=%b want 1 00 1", rd_ack, dout, empty);
    end
`else
    if (rd_ack !== 1'b1 || dout !== 8'h3C || empty !== 1'b1) begin
      n_err++; $display("FAIL reg_pop got ack=%b dout=%h empty=%b want 1 3c 1", rd_ack, dout, empty);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_drain();
    test_empty_read();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised synchronous FIFO.
- Successor to the team's dual-clock FIFO. It keeps the same write/read handshake family: ack/err, full/almost_full, empty/almost_empty.
- Adds three things:
  - Generic width and depth.
  - Run-time programmable almost-full/almost-empty thresholds.
  - A live fill-level output.
- Sits between a single-domain producer and consumer, e.g. a packet buffer in a datapath.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries. Must be a power of 2, >= 4.
- AW, $clog2(DEPTH): pointer width. Derived; not to be overridden.

Ports:
- clk  input  1  single clock, rising-edge.
- clear_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- din  input  WIDTH  write data.
- wr_ack  output  1  registered pulse: previous-cycle write accepted.
- wr_err  output  1  registered pulse: previous-cycle write rejected.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= af_thresh.
- rd_en  input  1  read request.
- dout  output  WIDTH  read data.
- rd_ack  output  1  registered pulse: previous-cycle read accepted; dout valid.
- rd_err  output  1  registered pulse: previous-cycle read rejected.
- empty  output  1  count == 0.
- almost_empty  output  1  count <= ae_thresh.
- af_thresh  input  AW+1  almost-full threshold. Sampled every cycle; quasi-static.
- ae_thresh  input  AW+1  almost-empty threshold. Sampled every cycle; quasi-static.
- count  output  AW+1  current number of stored entries, 0..DEPTH.

Behaviour:
- Single clock clk; reset clear_n is asynchronous, active-low. Every register is cleared immediately on clear_n=0 and released synchronously at the next clk edge after deassertion.
- Reset values:
  - wr_ack, wr_err, rd_ack, rd_err, full = 0.
  - dout = 0, count = 0, wr_ptr = rd_ptr = 0.
  - empty = 1, almost_empty = 1.
  - almost_full = 1 only if af_thresh == 0.
- Memory contents are not cleared by reset.
- Read accept (rd_acc) = rd_en && !empty. A read while empty is rejected even if a write occurs in the same cycle.
- Write accept (wr_acc) = wr_en && (!full || rd_acc). Simultaneous read and write at full is legal: both complete and count stays DEPTH.
- Accepted write: mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH (natural AW-bit wrap).
- Accepted read: dout <= mem[rd_ptr] at the same edge; rd_ptr increments modulo DEPTH.
- Read latency is 1 cycle: dout and rd_ack are valid together in the cycle after rd_en. dout holds its last value otherwise.
- Ack/err pulses:
  - wr_ack <= wr_acc; wr_err <= wr_en && !wr_acc.
  - rd_ack <= rd_acc; rd_err <= rd_en && !rd_acc.
  - Each is high for exactly one cycle per request.
- count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both or neither.
- Flags are combinational decodes of the registered count, so they change in the cycle after the causing operation.
- Thresholds:
  - af_thresh > DEPTH makes almost_full never assert.
  - ae_thresh >= DEPTH makes almost_empty always assert.
  - A threshold change takes effect the same cycle (combinational compare).
- Reset mid-operation: any pending ack/err is discarded; the FIFO reads as empty after release.

Optional Feature:
- Macro SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - rd_en pops the shown word.
  - A word written to an empty FIFO appears on dout in the cycle after the write, together with empty deasserting.
  - rd_ack/rd_err timing is unchanged.
- Undefined: registered 1-cycle-latency read as above.

Decomposition:
- Package sync_fifo_pkg:
  - Function clog2-based pointer width helper.
  - Typedef of the thresholds/count width for the default configuration.
  - Localparam defaults WIDTH_DEF=8, DEPTH_DEF=16.
- Sub-module sync_fifo_ram:
  - DEPTH x WIDTH register array.
  - Synchronous write port.
  - Asynchronous read port.
  - The top level registers dout in non-FWFT mode.

Test Plan (WIDTH=8, DEPTH=16, af_thresh=14, ae_thresh=2):
- Reset, then write 0x01..0x10 over 16 cycles:
  - 16 wr_ack pulses.
  - almost_empty drops after the 3rd write.
  - almost_full rises after the 14th write.
  - full=1 and count=16 after the 16th write.
- Full FIFO, 17th write without read -> wr_err=1 for 1 cycle, count stays 16, contents unchanged.
- Full FIFO, simultaneous wr_en (din=0xAA) and rd_en -> wr_ack=rd_ack=1, dout=0x01, count=16. 0xAA is read last.
- Empty FIFO, rd_en alone -> rd_err=1, dout unchanged. Empty FIFO, rd_en plus wr_en of 0x55 -> rd_err=1, wr_ack=1, count=1.
- Wrap: 40 interleaved write/read pairs with incrementing data -> in-order output 0..39, no err pulses, pointers wrap twice.
- Assert clear_n=0 mid-burst with count=9 -> flags and count reset immediately. After release, rd_en gives rd_err. Repeat the scenario with SYNC_FIFO_FWFT_EN to confirm dout shows the head word with no read latency.
